instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the decoder/control block: owns the PC, drives the
//  instruction memory through a req/ack handshake and presents one 32-bit
//  instruction (opcode field = instr[31:21]) to decode with a valid/ready
//  handshake. The next PC is resolved from the branch/uncond_branch/zero/
//  imm info returned for the instruction being consumed.
//  Non-pipelined: one instruction in flight at a time.
// PARAMETERS
//  PC_W      64   PC, address and immediate width (bits)
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  CLK            in   1     clock, rising edge
//  Reset_L        in   1     reset, asynchronous, active-low
//  imem_req       out  1     fetch request to instruction memory
//  imem_addr      out  PC_W  fetch address (= current PC)
//  imem_ack       in   1     memory has imem_rdata valid this cycle
//  imem_rdata     in   32    instruction word
//  instr          out  32    instruction to decode
//  instr_pc       out  PC_W  PC of instr
//  instr_valid    out  1     instr/instr_pc valid
//  instr_ready    in   1     decode accepts instr this cycle
//  branch         in   1     conditional branch (CBZ) flag for current instr
//  uncond_branch  in   1     unconditional branch (B) flag for current instr
//  zero           in   1     ALU zero flag for current instr
//  br_imm         in   PC_W  sign-extended word offset for current instr
//  halt           in   1     stop fetching after current instr is consumed
//  halted         out  1     fetch unit in HALT state
// BEHAVIOUR
//  Reset (async, Reset_L=0): state=IDLE, pc=RESET_PC, imem_req=0,
//   instr_valid=0, instr=0, instr_pc=0, halted=0; imem_addr follows pc.
//  States: IDLE -> REQ (unconditional, 1 cycle after reset release).
//   REQ: imem_req=1, imem_addr=pc held stable until imem_ack; on ack latch
//    instr<=imem_rdata, instr_pc<=pc, go HOLD. Ack in the same cycle as the
//    first req cycle is legal (zero-wait memory).
//   HOLD: instr_valid=1, instr/instr_pc stable while instr_ready=0. On
//    instr_valid&instr_ready: pc<=next_pc; go HALT if halt=1, else REQ.
//   HALT: imem_req=0, instr_valid=0, halted=1; exit only via reset.
//  imem_ack outside REQ is ignored. Branch inputs, zero and halt are
//   sampled only in the HOLD handshake cycle.
//  next_pc: taken = uncond_branch | (branch & zero);
//   taken ? pc + (br_imm << 2) : pc + 4; PC_W-bit modulo (wrap, no flag).
//  Latency: req->valid = ack wait + 1 cycle; best throughput one instr per
//   2 cycles (REQ, HOLD).
//  Reset mid-REQ or mid-HOLD: outputs return to reset values immediately;
//   in-flight ack/data discarded.
// CONFIGURATION
//  FETCH_STATS_EN defined: adds outputs stat_fetched[31:0] (+1 on each
//   HOLD handshake) and stat_taken[31:0] (+1 on each handshake with
//   taken=1); both reset to 0, wrap at 2^32, stop counting in HALT.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, ack tied high, ready high, no branches -> instr_pc sequence
//    0,4,8,12; instr_valid every 2nd cycle; imem_addr=0 in first REQ.
//  2 ack delayed 3 cycles at pc=4 -> imem_req=1, imem_addr=4 stable 4
//    cycles; instr_valid exactly 1 cycle after ack; ready low 2 cycles ->
//    instr held.
//  3 At pc=8: branch=1, zero=1, br_imm=-2 -> next fetch addr 0; same with
//    zero=0 -> 12; uncond_branch=1, br_imm=5 at pc=0x10 -> 0x24.
//  4 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, sequential -> next fetch addr 0.
//  5 halt=1 on handshake at pc=4 -> halted=1, imem_req=0 thereafter;
//    Reset_L low for 1 cycle mid-REQ -> imem_req=0 immediately, restart at
//    RESET_PC.
//  6 FETCH_STATS_EN: 5 instrs incl. 2 taken -> stat_fetched=5,
//    stat_taken=2.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit bus: instruction memory, decode handoff, branch feedback, halt
interface instr_fetch_unit_if #(
  parameter int PC_W = 64
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            branch;
  logic            uncond_branch;
  logic            zero;
  logic [PC_W-1:0] br_imm;
  logic            halt;
  logic            halted;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
    input  imem_ack, imem_rdata, instr_ready, branch, uncond_branch, zero, br_imm, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
    output imem_ack, imem_rdata, instr_ready, branch, uncond_branch, zero, br_imm, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - non-pipelined fetch stage owning the PC; FETCH_STATS_EN adds fetch/taken counters
module instr_fetch_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset_L,
  instr_fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_taken
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] next_pc;
  logic [31:0]     instr_q;
  logic [PC_W-1:0] instr_pc_q;
  logic            taken;
  logic            handshake;

  // Branch resolution only matters in the HOLD handshake cycle; elsewhere it is unused.
  assign handshake = (state == HOLD) && bus.instr_ready;
  assign taken     = bus.uncond_branch | (bus.branch & bus.zero);
  assign next_pc   = taken ? (pc + (bus.br_imm << 2)) : (pc + PC_W'(4));

  assign bus.imem_addr = pc;
  assign bus.instr     = instr_q;
  assign bus.instr_pc  = instr_pc_q;

  // State register.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; HALT is left only through reset.
  always_comb begin
    state_nxt       = state;
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    bus.halted      = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
      end
      REQ: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        bus.instr_valid = 1'b1;
        if (bus.instr_ready) begin
          state_nxt = bus.halt ? HALT : REQ;
        end
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // PC advance on consume, instruction capture on memory ack (ack outside REQ is ignored).
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      pc         <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      if ((state == REQ) && bus.imem_ack) begin
        instr_q    <= bus.imem_rdata;
        instr_pc_q <= pc;
      end
      if (handshake) begin
        pc <= next_pc;
      end
    end
  end

`ifdef FETCH_STATS_EN
  // Consumed-instruction and taken-branch counters; they freeze once HALT is reached.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      stat_fetched <= '0;
      stat_taken   <= '0;
    end else if (handshake) begin
      stat_fetched <= stat_fetched + 32'd1;
      if (taken) begin
        stat_taken <= stat_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized fetch-unit bench against a transaction-level PC/memory model
module tb_instr_fetch_unit;

  logic CLK = 1'b0;
  logic Reset_L;

  always #5 CLK = ~CLK;

  instr_fetch_unit_if #(.PC_W(64)) bus0 ();
  instr_fetch_unit_if #(.PC_W(64)) bus1 ();

`ifdef FETCH_STATS_EN
  logic [31:0] sf0, st0, sf1, st1;
`endif

  instr_fetch_unit #(.PC_W(64), .RESET_PC(64'd0)) dut0 (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus0)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (sf0),
    .stat_taken   (st0)
`endif
  );

  instr_fetch_unit #(.PC_W(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus1)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (sf1),
    .stat_taken   (st1)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: architectural PC plus consumed/taken counts.
  logic [63:0] m_pc;
  int unsigned m_fetched;
  int unsigned m_taken;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef FETCH_STATS_EN
    check({tag, "_stat_fetched"}, 64'(sf0), 64'(m_fetched));
    check({tag, "_stat_taken"}, 64'(st0), 64'(m_taken));
`else
    if (tag.len() < 0) check(tag, 64'd0, 64'd1);
`endif
  endtask

  // One complete instruction: REQ with 'waits' stall cycles, HOLD with 'rdly' ready-low cycles, then consume.
  task automatic fetch_one(input int waits, input int rdly, input bit br, input bit ubr,
                           input bit z, input logic [63:0] imm, input bit hlt);
    logic [31:0] w;
    bit          tk;
    check("req_start", 64'(bus0.imem_req), 64'd1);
    check("addr_start", bus0.imem_addr, m_pc);
    check("valid_in_req", 64'(bus0.instr_valid), 64'd0);
    for (int i = 0; i < waits; i++) begin
      bus0.imem_ack   = 1'b0;
      bus0.imem_rdata = $urandom;
      tick();
      check("req_wait", 64'(bus0.imem_req), 64'd1);
      check("addr_wait", bus0.imem_addr, m_pc);
      check("valid_wait", 64'(bus0.instr_valid), 64'd0);
    end
    w = mem_word(m_pc);
    bus0.imem_ack   = 1'b1;
    bus0.imem_rdata = w;
    bus0.instr_ready = 1'b0;
    tick();
    bus0.imem_ack = 1'b0;
    check("valid_after_ack", 64'(bus0.instr_valid), 64'd1);
    check("req_in_hold", 64'(bus0.imem_req), 64'd0);
    check("instr", 64'(bus0.instr), 64'(w));
    check("instr_pc", bus0.instr_pc, m_pc);
    for (int i = 0; i < rdly; i++) begin
      bus0.imem_ack      = 1'($urandom_range(0, 1));
      bus0.imem_rdata    = $urandom;
      bus0.branch        = 1'($urandom_range(0, 1));
      bus0.uncond_branch = 1'($urandom_range(0, 1));
      bus0.zero          = 1'($urandom_range(0, 1));
      bus0.halt          = 1'($urandom_range(0, 1));
      tick();
      check("valid_held", 64'(bus0.instr_valid), 64'd1);
      check("instr_held", 64'(bus0.instr), 64'(w));
      check("instr_pc_held", bus0.instr_pc, m_pc);
    end
    bus0.imem_ack      = 1'b0;
    bus0.instr_ready   = 1'b1;
    bus0.branch        = br;
    bus0.uncond_branch = ubr;
    bus0.zero          = z;
    bus0.br_imm        = imm;
    bus0.halt          = hlt;
    tick();
    tk = ubr | (br & z);
    m_pc = tk ? m_pc + (imm << 2) : m_pc + 64'd4;
    m_fetched++;
    if (tk) m_taken++;
    bus0.instr_ready   = 1'b0;
    bus0.branch        = 1'($urandom_range(0, 1));
    bus0.uncond_branch = 1'($urandom_range(0, 1));
    bus0.zero          = 1'($urandom_range(0, 1));
    bus0.halt          = 1'($urandom_range(0, 1));
    bus0.br_imm        = {$urandom, $urandom};
    check("halted_after_consume", 64'(bus0.halted), 64'(hlt));
    check("valid_after_consume", 64'(bus0.instr_valid), 64'd0);
    check_stats("consume");
  endtask

  task automatic model_reset();
    m_pc      = 64'd0;
    m_fetched = 0;
    m_taken   = 0;
  endtask

  initial begin
    logic [63:0] imm;
    int          s;

    Reset_L = 1'b0;
    bus0.imem_ack = 1'b0; bus0.imem_rdata = '0; bus0.instr_ready = 1'b0;
    bus0.branch = 1'b0; bus0.uncond_branch = 1'b0; bus0.zero = 1'b0;
    bus0.br_imm = '0; bus0.halt = 1'b0;
    bus1.imem_ack = 1'b0; bus1.imem_rdata = '0; bus1.instr_ready = 1'b0;
    bus1.branch = 1'b0; bus1.uncond_branch = 1'b0; bus1.zero = 1'b0;
    bus1.br_imm = '0; bus1.halt = 1'b0;
    model_reset();

    // Reset values, even with ack asserted during reset.
    tick();
    bus0.imem_ack = 1'b1;
    tick();
    bus0.imem_ack = 1'b0;
    check("rst_req", 64'(bus0.imem_req), 64'd0);
    check("rst_valid", 64'(bus0.instr_valid), 64'd0);
    check("rst_instr", 64'(bus0.instr), 64'd0);
    check("rst_instr_pc", bus0.instr_pc, 64'd0);
    check("rst_halted", 64'(bus0.halted), 64'd0);
    check("rst_addr", bus0.imem_addr, 64'd0);
    check("rst_addr_dut1", bus1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check_stats("rst");

    // IDLE for one cycle after release, then REQ.
    Reset_L = 1'b1;
    check("idle_req", 64'(bus0.imem_req), 64'd0);
    tick();

    // Wrapping reset PC on the second instance.
    check("wrap_req", 64'(bus1.imem_req), 64'd1);
    check("wrap_addr0", bus1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    bus1.imem_ack = 1'b1;
    bus1.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus1.imem_ack = 1'b0;
    check("wrap_valid", 64'(bus1.instr_valid), 64'd1);
    check("wrap_instr", 64'(bus1.instr), 64'hDEAD_BEEF);
    check("wrap_instr_pc", bus1.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    bus1.instr_ready = 1'b1;
    tick();
    bus1.instr_ready = 1'b0;
    check("wrap_addr1", bus1.imem_addr, 64'd0);
    check("wrap_req1", 64'(bus1.imem_req), 64'd1);

    // Sequential zero-wait fetches, stall/hold, and the directed branch cases.
    fetch_one(0, 0, 0, 0, 0, 64'd0, 0);
    fetch_one(3, 2, 0, 0, 0, 64'd0, 0);
    fetch_one(0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    check("cbz_taken_addr", bus0.imem_addr, 64'd0);
    fetch_one(0, 0, 0, 0, 0, 64'd0, 0);
    fetch_one(0, 0, 0, 0, 0, 64'd0, 0);
    fetch_one(0, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    check("cbz_not_taken_addr", bus0.imem_addr, 64'd12);
    fetch_one(0, 0, 0, 0, 0, 64'd0, 0);
    fetch_one(0, 0, 0, 1, 0, 64'd5, 0);
    check("b_addr", bus0.imem_addr, 64'h24);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        imm = {$urandom, $urandom};
      end else begin
        s = int'($urandom_range(0, 200)) - 100;
        imm = {{32{s[31]}}, s};
      end
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), imm, 0);
    end

    // Halt: no further requests, stats frozen, ack ignored.
    fetch_one(1, 1, 0, 0, 0, 64'd0, 1);
    for (int i = 0; i < 4; i++) begin
      bus0.imem_ack = 1'b1;
      bus0.instr_ready = 1'b1;
      tick();
      check("halt_req", 64'(bus0.imem_req), 64'd0);
      check("halt_halted", 64'(bus0.halted), 64'd1);
      check("halt_valid", 64'(bus0.instr_valid), 64'd0);
      check_stats("halt");
    end
    bus0.imem_ack = 1'b0;
    bus0.instr_ready = 1'b0;

    // Reset out of HALT, then a reset pulse mid-REQ with data in flight.
    Reset_L = 1'b0;
    #1;
    check("halt_rst_halted", 64'(bus0.halted), 64'd0);
    tick();
    Reset_L = 1'b1;
    model_reset();
    tick();
    fetch_one(0, 0, 0, 0, 0, 64'd0, 0);
    fetch_one(0, 1, 0, 1, 0, 64'd40, 0);
    tick();
    check("midreq_req_before", 64'(bus0.imem_req), 64'd1);
    Reset_L = 1'b0;
    #1;
    check("midreq_req_now", 64'(bus0.imem_req), 64'd0);
    check("midreq_addr_now", bus0.imem_addr, 64'd0);
    bus0.imem_ack = 1'b1;
    bus0.imem_rdata = 32'h1234_5678;
    tick();
    bus0.imem_ack = 1'b0;
    check("midreq_instr", 64'(bus0.instr), 64'd0);
    check("midreq_valid", 64'(bus0.instr_valid), 64'd0);
    Reset_L = 1'b1;
    model_reset();
    check_stats("midreq");
    tick();
    fetch_one(2, 0, 0, 0, 0, 64'd0, 0);
    fetch_one(0, 0, 1, 0, 1, 64'd3, 0);

    // Reset mid-HOLD clears the presented instruction immediately.
    bus0.imem_ack = 1'b1;
    bus0.imem_rdata = 32'hCAFE_F00D;
    tick();
    bus0.imem_ack = 1'b0;
    check("midhold_valid_before", 64'(bus0.instr_valid), 64'd1);
    Reset_L = 1'b0;
    #1;
    check("midhold_valid_now", 64'(bus0.instr_valid), 64'd0);
    check("midhold_instr_now", 64'(bus0.instr), 64'd0);
    check("midhold_instr_pc_now", bus0.instr_pc, 64'd0);
    tick();
    Reset_L = 1'b1;
    model_reset();
    tick();
    fetch_one(0, 0, 0, 0, 0, 64'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
